// File: rtl/alu_defs.sv
// Shared opcode/funct3 encodings, ROB tag width and FSM state type for the ALU.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package alu_defs;

    localparam int ROB_TAG_W = `ROB_SIZE_WIDTH;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Integer funct3 (OP / OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // M-extension multiply funct3[1:0]
    localparam logic [1:0] F3_MUL    = 2'b00;
    localparam logic [1:0] F3_MULH   = 2'b01;
    localparam logic [1:0] F3_MULHSU = 2'b10;
    localparam logic [1:0] F3_MULHU  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative radix-2 shift-add multiplier: one partial product per cycle on operand
// magnitudes, sign restored on the final product. Built only when ALU_MUL_EN is defined.
module alu_mul_iter
    import alu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic                running;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic                neg;
    logic [1:0]          func;

    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [2*XLEN-1:0]   product;

    // MULHU treats both operands unsigned; MULHSU only the first as signed.
    assign a_neg = (funct3 != F3_MULHU) && a[XLEN-1];
    assign b_neg = (funct3 == F3_MUL || funct3 == F3_MULH) && b[XLEN-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    assign done    = running && (cnt == CNT_W'(XLEN));
    assign product = neg ? -acc : acc;
    assign result  = (func == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values; blocking here would make the iteration order-dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            func    <= F3_MUL;
        end else if (abort) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (rdy) begin
            if (start) begin
                running <= 1'b1;
                cnt     <= '0;
                acc     <= '0;
                mcand   <= {{XLEN{1'b0}}, mag_a};
                mplier  <= mag_b;
                neg     <= a_neg ^ b_neg;
                func    <= funct3;
            end else if (running) begin
                if (done) begin
                    running <= 1'b0;
                end else begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_unit.sv
// RV32I integer/branch execution unit with a registered result broadcast.
// Define ALU_MUL_EN to add the iterative M-extension multiplier and its IDLE/MUL FSM.
module alu_unit
    import alu_defs::*;
#(
    parameter int ROB_ID_W = ROB_TAG_W,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                rob_clear,
    input  logic                valid,
    input  logic [2:0]          op,
    input  logic [6:0]          instr_type,
    input  logic                op_other,
    input  logic                op_mul,
    input  logic [XLEN-1:0]     v1,
    input  logic [XLEN-1:0]     v2,
    input  logic [ROB_ID_W-1:0] rob_id,
    output logic                busy,
    output logic                result_ready,
    output logic [ROB_ID_W-1:0] result_rob_id,
    output logic [XLEN-1:0]     result_value
);

    localparam int SHW = $clog2(XLEN);

    logic                accept;
    logic                mul_start;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     sum;
    logic [XLEN-1:0]     diff;
    logic [XLEN-1:0]     sra_value;
    logic                eq;
    logic                lt_s;
    logic                lt_u;
    logic                sub_en;
    logic                taken;
    logic [XLEN-1:0]     arith_value;
    logic [XLEN-1:0]     alu_value;

    logic                ready_d;
    logic [ROB_ID_W-1:0] tag_d;
    logic [XLEN-1:0]     value_d;

    assign accept = rdy && !rob_clear && valid && !busy;

    assign shamt     = v2[SHW-1:0];
    assign sum       = v1 + v2;
    assign diff      = v1 - v2;
    assign sra_value = $signed(v1) >>> shamt;
    assign eq        = (v1 == v2);
    assign lt_s      = $signed(v1) < $signed(v2);
    assign lt_u      = v1 < v2;
    // OP-IMM reuses bit 30 as immediate data for ADDI, so only OP may subtract.
    assign sub_en    = (instr_type == OPC_OP) && op_other;

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        arith_value = sum;
        case (op)
            F3_ADD:  arith_value = sub_en ? diff : sum;
            F3_SLL:  arith_value = v1 << shamt;
            F3_SLT:  arith_value = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: arith_value = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  arith_value = v1 ^ v2;
            F3_SR:   arith_value = op_other ? sra_value : (v1 >> shamt);
            F3_OR:   arith_value = v1 | v2;
            F3_AND:  arith_value = v1 & v2;
            default: arith_value = sum;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (op)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_value = sum;
        case (instr_type)
            OPC_OP:     alu_value = arith_value;
            OPC_OP_IMM: alu_value = arith_value;
            OPC_BRANCH: alu_value = {{(XLEN-1){1'b0}}, taken};
            default:    alu_value = sum;
        endcase
`ifdef ALU_MUL_EN
        // M-extension funct3 1xx yields zero with single-cycle latency.
        if (instr_type == OPC_OP && op_mul && op[2]) begin
            alu_value = '0;
        end
`endif
    end

`ifdef ALU_MUL_EN
    alu_state_e          state;
    logic [ROB_ID_W-1:0] mul_tag;
    logic                mul_done;
    logic [XLEN-1:0]     mul_result;

    assign mul_start = accept && (instr_type == OPC_OP) && op_mul && !op[2];
    assign busy      = (state == ST_MUL);

    alu_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .rdy    (rdy),
        .start  (mul_start),
        .abort  (rob_clear),
        .funct3 (op[1:0]),
        .a      (v1),
        .b      (v2),
        .done   (mul_done),
        .result (mul_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mul_tag <= '0;
        end else if (rob_clear) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        state   <= ST_MUL;
                        mul_tag <= rob_id;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_op_mul;

    assign unused_op_mul = op_mul;
    assign mul_start     = 1'b0;
    assign busy          = 1'b0;
`endif

    always_comb begin
        ready_d = 1'b0;
        tag_d   = result_rob_id;
        value_d = result_value;
        if (accept && !mul_start) begin
            ready_d = 1'b1;
            tag_d   = rob_id;
            value_d = alu_value;
        end
`ifdef ALU_MUL_EN
        // Completion only happens in MUL, where busy already blocks any accept.
        if (mul_done) begin
            ready_d = 1'b1;
            tag_d   = mul_tag;
            value_d = mul_result;
        end
`endif
    end

    // rob_clear drops a pending pulse even while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_ready  <= 1'b0;
            result_rob_id <= '0;
            result_value  <= '0;
        end else if (rob_clear) begin
            result_ready <= 1'b0;
        end else if (rdy) begin
            result_ready  <= ready_d;
            result_rob_id <= tag_d;
            result_value  <= value_d;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus queues expected broadcasts, a negedge monitor pops them.
module tb_alu_unit;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        rob_clear;
    logic        valid;
    logic [2:0]  op;
    logic [6:0]  instr_type;
    logic        op_other;
    logic        op_mul;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  rob_id;
    logic        busy;
    logic        result_ready;
    logic [3:0]  result_rob_id;
    logic [31:0] result_value;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .rob_clear     (rob_clear),
        .valid         (valid),
        .op            (op),
        .instr_type    (instr_type),
        .op_other      (op_other),
        .op_mul        (op_mul),
        .v1            (v1),
        .v2            (v2),
        .rob_id        (rob_id),
        .busy          (busy),
        .result_ready  (result_ready),
        .result_rob_id (result_rob_id),
        .result_value  (result_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every broadcast pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && result_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got tag %0d value 0x%08h, want no broadcast",
                         result_rob_id, result_value);
            end else begin
                e = exp_q.pop_front();
                check("pulse_tag", {28'd0, result_rob_id}, {28'd0, e.tag});
                check("pulse_value", result_value, e.value);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] it, input logic [2:0] f3, input logic oo, input logic om,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        valid      = 1'b1;
        instr_type = it;
        op         = f3;
        op_other   = oo;
        op_mul     = om;
        v1         = a;
        v2         = b;
        rob_id     = tag;
    endtask

    task automatic issue(input logic [6:0] it, input logic [2:0] f3, input logic oo, input logic om,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp_value);
        drive(it, f3, oo, om, a, b, tag);
        exp_q.push_back(exp_t'{tag: tag, value: exp_value});
        step();
    endtask

    task automatic idle(input int n);
        valid     = 1'b0;
        rob_clear = 1'b0;
        repeat (n) step();
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] exp_value);
        issue(OP, f3, 1'b0, 1'b1, a, b, tag, exp_value);
        idle(36);
    endtask
`endif

    initial begin
        rst_n = 1'b0; rdy = 1'b1; rob_clear = 1'b0; valid = 1'b0;
        op = '0; instr_type = '0; op_other = 1'b0; op_mul = 1'b0;
        v1 = '0; v2 = '0; rob_id = '0;
        #12;
        check("reset_ready", {31'd0, result_ready}, 32'd0);
        check("reset_tag", {28'd0, result_rob_id}, 32'd0);
        check("reset_value", result_value, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // SUB with a one-cycle pulse that drops afterwards
        issue(OP, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 4'd3, 32'hFFFF_FFFE);
        valid = 1'b0;
        step();
        check("pulse_low", {31'd0, result_ready}, 32'd0);

        issue(OP_IMM, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 4'd4, 32'hF800_0000);
        issue(OP_IMM, 3'b000, 1'b1, 1'b0, 32'h8000_0000, 32'h400, 4'd5, 32'h8000_0400);
        issue(BRANCH, 3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd0);
        issue(BRANCH, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd1);
        idle(2);

        // Back-to-back tags 1,2,3
        issue(OP, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 4'd1, 32'd3);
        issue(OP, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd2, 32'hFF00_FF00);
        issue(OP, 3'b001, 1'b0, 1'b0, 32'd3, 32'h21, 4'd3, 32'd6);
        idle(2);

        // Remaining table entries and boundaries
        issue(OP, 3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 4'd10, 32'd1);
        issue(OP, 3'b011, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 4'd11, 32'd0);
        issue(OP, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 4'd12, 32'h0800_0000);
        issue(OP, 3'b110, 1'b0, 1'b0, 32'h0F00_00F0, 32'h00F0_0F00, 4'd13, 32'h0FF0_0FF0);
        issue(OP, 3'b111, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd14, 32'h0F00_0F00);
        issue(OP, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd15, 32'd0);
        issue(BRANCH, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 4'd1, 32'd1);
        issue(BRANCH, 3'b001, 1'b0, 1'b0, 32'd9, 32'd9, 4'd2, 32'd0);
        issue(BRANCH, 3'b101, 1'b0, 1'b0, 32'd5, 32'd5, 4'd3, 32'd1);
        issue(BRANCH, 3'b111, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 4'd4, 32'd0);
        issue(BRANCH, 3'b010, 1'b0, 1'b0, 32'd1, 32'd1, 4'd5, 32'd0);
        issue(LUI, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 4'd6, 32'd1);
        idle(2);

        // rob_clear discards a same-cycle dispatch
        drive(OP, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 4'd5);
        rob_clear = 1'b1;
        step();
        rob_clear = 1'b0;
        valid     = 1'b0;
        check("clear_no_pulse", {31'd0, result_ready}, 32'd0);
        issue(OP, 3'b000, 1'b0, 1'b0, 32'd100, 32'd23, 4'd9, 32'd123);
        idle(2);

        // rdy low blocks acceptance
        drive(OP, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 4'd12);
        rdy = 1'b0;
        step();
        check("rdy_low_no_pulse", {31'd0, result_ready}, 32'd0);
        rdy = 1'b1;
        idle(2);

`ifdef ALU_MUL_EN
        begin
            int busy_cycles;
            int pulse_at;
            issue(OP, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 4'd6, 32'hFFFF_FFFF);
            drive(OP, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 4'd10);
            busy_cycles = (busy === 1'b1) ? 1 : 0;
            pulse_at    = -1;
            for (int i = 1; i <= 40; i++) begin
                step();
                if (i == 5) valid = 1'b0;
                if (busy === 1'b1) busy_cycles++;
                if (result_ready === 1'b1 && pulse_at < 0) pulse_at = i;
            end
            check("mul_busy_cycles", busy_cycles, 32'd33);
            check("mul_latency", pulse_at, 32'd33);
        end
        idle(2);

        mul_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'hFFFF_FFFE);
        mul_op(3'b000, 32'hFFFF_FFFD, 32'd5, 4'd8, 32'hFFFF_FFF1);
        mul_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 32'hFFFF_FFFF);
        issue(OP, 3'b100, 1'b0, 1'b1, 32'd100, 32'd7, 4'd10, 32'd0);
        idle(2);

        // Abort an in-flight multiply at T+10
        drive(OP, 3'b000, 1'b0, 1'b1, 32'd3, 32'd4, 4'd11);
        step();
        valid = 1'b0;
        repeat (9) step();
        rob_clear = 1'b1;
        step();
        rob_clear = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        idle(40);
        mul_op(3'b000, 32'd3, 32'd4, 4'd12, 32'd12);
`else
        issue(OP, 3'b000, 1'b0, 1'b1, 32'd3, 32'd4, 4'd13, 32'd7);
        check("busy_const", {31'd0, busy}, 32'd0);
        idle(2);
`endif

        idle(3);
        check("drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
